// File: rtl/riscv_commit_tracer_if.sv
// Retirement tap and trace stream bus for riscv_commit_tracer.
// With COMMIT_TRACE_TSTAMP_EN defined the record carries a 32-bit cycle stamp in its MSBs.
interface riscv_commit_tracer_if #(
    parameter int unsigned DMEM_AW = 8
);
`ifdef COMMIT_TRACE_TSTAMP_EN
    localparam int unsigned TRACE_W = 32 + 32 + 1 + 5 + 32 + 1 + DMEM_AW + 32;
`else
    localparam int unsigned TRACE_W = 32 + 1 + 5 + 32 + 1 + DMEM_AW + 32;
`endif

    logic                retire_valid;
    logic [31:0]         retire_pc;
    logic [31:0]         retire_instr;
    logic                rd_we;
    logic [4:0]          rd_addr;
    logic [31:0]         rd_data;
    logic                mem_we;
    logic [DMEM_AW-1:0]  mem_addr;
    logic [31:0]         mem_wdata;
    logic                trace_valid;
    logic                trace_ready;
    logic [TRACE_W-1:0]  trace_data;

    // Core/sink side
    modport master (
        output retire_valid, retire_pc, retire_instr, rd_we, rd_addr, rd_data,
               mem_we, mem_addr, mem_wdata, trace_ready,
        input  trace_valid, trace_data
    );

    // Tracer side
    modport slave (
        input  retire_valid, retire_pc, retire_instr, rd_we, rd_addr, rd_data,
               mem_we, mem_addr, mem_wdata, trace_ready,
        output trace_valid, trace_data
    );
endinterface

// File: rtl/riscv_commit_tracer.sv
// Commit tracer: canonicalises retired instructions into records, buffers them in a FIFO
// and streams them out; optional cycle stamp field under COMMIT_TRACE_TSTAMP_EN.
module riscv_commit_tracer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DMEM_AW    = 8,
    parameter logic [31:0] HALT_INSTR = 32'h00000063
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trace_en,
    input  logic                  clear,
    riscv_commit_tracer_if.slave  bus,
    output logic [31:0]           retired_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  overflow,
    output logic                  halted
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
`ifdef COMMIT_TRACE_TSTAMP_EN
        logic [31:0]        tstamp;
`endif
        logic [31:0]        mem_wdata;
        logic [DMEM_AW-1:0] mem_addr;
        logic               mem_we;
        logic [31:0]        rd_data;
        logic [4:0]         rd_addr;
        logic               rd_we;
        logic [31:0]        pc;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             rec_c;
    rec_t             head_q;
    rec_t             head_next;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next;
    logic [CNT_W-1:0] count, count_next;
    logic             valid_q;
    logic             capture, full, push, pop, drop;
`ifdef COMMIT_TRACE_TSTAMP_EN
    logic [31:0]      tstamp_q;
`endif

    // Canonical record: writes to x0 and non-store cycles carry no payload
    always_comb begin
        rec_c    = '0;
        rec_c.pc = bus.retire_pc;
        if (bus.rd_we && bus.rd_addr != 5'd0) begin
            rec_c.rd_we   = 1'b1;
            rec_c.rd_addr = bus.rd_addr;
            rec_c.rd_data = bus.rd_data;
        end
        if (bus.mem_we) begin
            rec_c.mem_we    = 1'b1;
            rec_c.mem_addr  = bus.mem_addr;
            rec_c.mem_wdata = bus.mem_wdata;
        end
`ifdef COMMIT_TRACE_TSTAMP_EN
        rec_c.tstamp = tstamp_q;
`endif
    end

    // FIFO control; head register is preloaded so the output stays purely registered
    always_comb begin
        capture     = bus.retire_valid & trace_en & ~halted & ~clear;
        full        = (count == CNT_W'(DEPTH));
        pop         = valid_q & bus.trace_ready & ~clear;
        push        = capture & (~full | pop);
        drop        = capture & full & ~pop;
        rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next  = count + CNT_W'(push) - CNT_W'(pop);
        if (count_next == '0)
            head_next = '0;
        else if (push && count == CNT_W'(pop))
            head_next = rec_c;
        else
            head_next = mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rec_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            rd_ptr  <= rd_ptr_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            count   <= count_next;
            valid_q <= (count_next != '0);
            head_q  <= head_next;
        end
    end

    // Retirement, drop and halt bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
        end else if (clear) begin
            retired_cnt <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (bus.retire_valid) retired_cnt <= retired_cnt + 32'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            if (capture && bus.retire_instr == HALT_INSTR) halted <= 1'b1;
        end
    end

`ifdef COMMIT_TRACE_TSTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     tstamp_q <= '0;
        else if (clear) tstamp_q <= '0;
        else            tstamp_q <= tstamp_q + 32'd1;
    end
`endif

    assign bus.trace_valid = valid_q;
    assign bus.trace_data  = head_q;
endmodule

// File: doc/riscv_commit_tracer.md
Name: riscv_commit_tracer

Overview:
- Sits directly downstream of the single-cycle RISC-V core (RISCV_Single_Cycle) and taps its retirement signals each cycle.
- Packs each retired instruction into a trace record: PC, register writeback and data-memory store.
- Buffers records in an internal FIFO and streams them out over a valid/ready interface to a trace sink or golden-model checker.
- Also provides a retired-instruction counter, halt detection, and drop/overflow accounting.

Parameters:
DEPTH, 16, FIFO depth in records; power of two, minimum 2.
DMEM_AW, 8, data-memory word-address width (256 words).
HALT_INSTR, 32'h00000063, instruction encoding treated as program halt (beq x0,x0,0).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
trace_en  in  1  capture enable
clear  in  1  synchronous flush of FIFO, counters and flags
retire_valid  in  1  core retired an instruction this cycle
retire_pc  in  32  PC of the retired instruction
retire_instr  in  32  instruction word
rd_we  in  1  register write enable
rd_addr  in  5  destination register
rd_data  in  32  writeback data
mem_we  in  1  DMEM store enable
mem_addr  in  DMEM_AW  DMEM word index
mem_wdata  in  32  store data
trace_valid  out  1  record available
trace_ready  in  1  sink accepts the record
trace_data  out  TRACE_W  head record
retired_cnt  out  32  instructions retired since reset/clear
drop_cnt  out  16  records dropped due to a full FIFO
overflow  out  1  sticky: at least one drop occurred
halted  out  1  sticky: HALT_INSTR retired

Behaviour:
- TRACE_W = 32 + 1 + 5 + 32 + 1 + DMEM_AW + 32 (111 at defaults).
- Record fields, MSB to LSB: mem_wdata, mem_addr, mem_we, rd_data, rd_addr, rd_we, pc.
- Canonicalisation:
  - rd_we with rd_addr==0 is recorded as rd_we=0, rd_addr=0, rd_data=0.
  - mem_we=0 forces mem_addr=0 and mem_wdata=0.
- Capture condition: capture = retire_valid & trace_en & ~halted & ~clear.
- Capture latency: a record captured on edge N appears on trace_data and trace_valid after edge N (first-word-fall-through from registered storage). No combinational path from retire_* to trace_*.
- Handshake:
  - trace_valid = (count != 0).
  - A record pops on a cycle with trace_valid & trace_ready.
  - trace_data holds stable while trace_valid=1 and trace_ready=0.
- Full FIFO:
  - A capture is accepted if a pop occurs in the same cycle.
  - Otherwise the record is dropped, drop_cnt increments (saturates at 16'hFFFF) and overflow sets.
- Empty FIFO: trace_ready is ignored and pointers are unchanged.
- Pointers: wrap modulo DEPTH. Count ranges 0..DEPTH and tracks simultaneous push and pop correctly.
- retired_cnt: increments on every retire_valid (independent of trace_en, halted and FIFO state) and wraps 0xFFFFFFFF -> 0.
- halted: sets on the cycle a capture occurs with retire_instr==HALT_INSTR. The halt record itself is captured; later retirements are not.
- clear: synchronous.
  - Empties the FIFO and zeroes retired_cnt, drop_cnt, overflow and halted.
  - Beats a same-cycle capture or pop.
- Reset: asynchronous, all state cleared. Outputs after reset: trace_valid=0, trace_data=0, retired_cnt=0, drop_cnt=0, overflow=0, halted=0. Reset mid-stream discards buffered records.

Optional Feature:
COMMIT_TRACE_TSTAMP_EN:
- Defined:
  - A free-running 32-bit cycle counter (reset/clear to 0, wraps) is prepended as the MSB field of each record.
  - TRACE_W grows by 32.
  - The stamp is the counter value on the capture cycle.
- Undefined: no counter and no field; TRACE_W as above.

Test Plan:
1. Reset, trace_en=1, trace_ready=1; retire PC 0x0 (addi x1,x0,5: rd_we=1, rd=1, data=5) -> next cycle trace_valid=1 with pc=0, rd_we=1, rd_addr=1, rd_data=5; retired_cnt=1.
2. Retire with rd_we=1, rd_addr=0, rd_data=0x1234 -> record shows rd_we=0, rd_addr=0, rd_data=0. Store mem_we=1, addr=8'h10, wdata=0xDEADBEEF -> fields captured exactly.
3. trace_ready=0 with 20 consecutive retirements, DEPTH=16 -> 16 buffered, drop_cnt=4, overflow=1. Drain -> records hold PCs 0x00..0x3C in order, then trace_valid=0.
4. FIFO full, trace_ready=1 with a same-cycle retirement -> no drop; count stays 16.
5. Retire HALT_INSTR at PC 0x1BC, then 3 more retirements -> halt record emitted, halted=1, no further records, retired_cnt still counts up.
6. Deassert rst_n mid-stream with 5 records buffered -> trace_valid=0 immediately, all counters 0. Pulse clear with a same-cycle retirement -> nothing captured.
